// File: rtl/angle_ramp.sv
// Servo angle slew limiter: takes fp16 target angles and walks an integer-degree
// position toward the target, at most STEP_DEG per servo frame. Drives an fp16 angle word.
module angle_ramp #(
   parameter int FRAME_CYCLES = 1_000_000,
   parameter int STEP_DEG     = 1,
   parameter int INIT_DEG     = 90
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_angle,
   output logic [15:0] angle,
   output logic        busy,
   output logic        frame_tick,
   output logic        cmd_err
);

   localparam int            CW      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_CYCLES - 1);
   localparam logic [7:0]    STEP    = 8'(STEP_DEG);
   localparam logic [7:0]    INIT    = 8'(INIT_DEG);

   typedef enum logic {IDLE, DECODE} state_t;

   // Integer degrees -> fp16; exact because d < 2^11.
   function automatic logic [15:0] enc(input logic [7:0] d);
      logic [15:0] w;
      logic [17:0] sh;
      w = '0;
      for (int p = 0; p < 8; p++) begin
         if (d[p]) begin
            sh = {10'b0, d} << (10 - p);
            w  = {1'b0, 5'(15 + p), sh[9:0]};
         end
      end
      return w;
   endfunction

   // fp16 -> {reject, degrees}, truncating toward zero and saturating at 180.
   function automatic logic [8:0] dec(input logic [15:0] w);
      logic [4:0]  e;
      logic [10:0] q;
      e = w[14:10];
      q = '0;
      if (e == 5'd31)
         return {1'b1, 8'd0};
      else if (w[15] || e < 5'd15)
         return '0;
      else if (e >= 5'd23)
         return {1'b0, 8'd180};
      q = {1'b1, w[9:0]} >> (5'd25 - e);
      return {1'b0, (q > 11'd180) ? 8'd180 : q[7:0]};
   endfunction

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [15:0]   cmd_q;
   logic [7:0]    cur, tgt, cur_nx, tgt_nx, diff, mv;
   logic [8:0]    dres;
   logic          err_nx;

   assign frame_tick = (cnt == CNT_MAX);

   always_comb begin
      state_nx  = state;
      cmd_ready = (state == IDLE);
      tgt_nx    = tgt;
      err_nx    = 1'b0;
      dres      = dec(cmd_q);
      case (state)
         IDLE:   if (cmd_valid) state_nx = DECODE;
         DECODE: begin
            state_nx = IDLE;
            if (dres[8]) err_nx = 1'b1;
            else         tgt_nx = dres[7:0];
         end
         default: state_nx = IDLE;
      endcase
   end

   // Stepping looks only at the pre-edge target, so a same-edge decode waits a frame.
   always_comb begin
      cur_nx = cur;
      diff   = (tgt > cur) ? (tgt - cur) : (cur - tgt);
      mv     = (diff < STEP) ? diff : STEP;
      if (frame_tick && cur != tgt)
         cur_nx = (tgt > cur) ? (cur + mv) : (cur - mv);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         cmd_q   <= '0;
         cur     <= INIT;
         tgt     <= INIT;
         angle   <= enc(INIT);
         busy    <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         cnt     <= frame_tick ? '0 : cnt + 1'b1;
         if (cmd_valid && cmd_ready) cmd_q <= cmd_angle;
         cur     <= cur_nx;
         tgt     <= tgt_nx;
         angle   <= enc(cur_nx);
         busy    <= (cur_nx != tgt_nx);
         cmd_err <= err_nx;
      end
   end

endmodule

// File: tb/tb_angle_ramp.sv
// Scoreboard bench for angle_ramp: two instances (STEP_DEG 1 and 4) share one command
// stream; a real-arithmetic model predicts every cycle, a monitor compares at negedge.
module tb_angle_ramp;

   localparam int FC = 16;

   logic        clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0;
   logic [15:0] cmd_angle = '0;
   logic [1:0]        cmd_ready, busy, frame_tick, cmd_err;
   logic [1:0][15:0]  angle;

   angle_ramp #(.FRAME_CYCLES(FC), .STEP_DEG(1), .INIT_DEG(90)) u0 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
      .cmd_angle(cmd_angle), .angle(angle[0]), .busy(busy[0]),
      .frame_tick(frame_tick[0]), .cmd_err(cmd_err[0]));

   angle_ramp #(.FRAME_CYCLES(FC), .STEP_DEG(4), .INIT_DEG(90)) u1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
      .cmd_angle(cmd_angle), .angle(angle[1]), .busy(busy[1]),
      .frame_tick(frame_tick[1]), .cmd_err(cmd_err[1]));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0][15:0] angle;
      logic [1:0]       busy, err, ready, tick;
   } exp_t;

   exp_t        q[$];
   int          m_cur[2], m_tgt[2], m_k;
   bit          m_pend;
   logic [15:0] m_word;
   int          n_chk = 0, n_pass = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // fp16 of an integer via the double-precision bit pattern.
   function automatic logic [15:0] m_enc(input int d);
      real         r;
      logic [63:0] b;
      if (d == 0) return 16'h0000;
      r = d;
      b = $realtobits(r);
      return {1'b0, 5'(b[62:52] - 11'd1008), b[51:42]};
   endfunction

   function automatic int m_dec(input logic [15:0] w, output bit bad);
      real r;
      int  e, d;
      e   = int'(w[14:10]);
      bad = (e == 31);
      r   = (1.0 + real'(w[9:0]) / 1024.0) * (2.0 ** (e - 15));
      if (w[15]) r = -r;
      d = $rtoi(r);
      if (d < 0)   d = 0;
      if (d > 180) d = 180;
      return d;
   endfunction

   // Reference model: one prediction per clock edge.
   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_cur = '{90, 90};
         m_tgt = '{90, 90};
         m_k = 0;
         m_pend = 1'b0;
         q.delete();
      end else begin
         exp_t e;
         bit   tick_e, bad;
         int   d, st, df;
         tick_e = (m_k % FC) == FC - 1;
         for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? 1 : 4;
            df = m_tgt[i] - m_cur[i];
            if (tick_e && df != 0) begin
               if (df > 0) m_cur[i] += (df < st) ? df : st;
               else        m_cur[i] -= (-df < st) ? -df : st;
            end
         end
         e = '0;
         if (m_pend) begin
            d = m_dec(m_word, bad);
            if (bad) e.err = 2'b11;
            else     m_tgt = '{d, d};
            m_pend = 1'b0;
         end else if (cmd_valid) begin
            m_word = cmd_angle;
            m_pend = 1'b1;
         end
         m_k++;
         for (int i = 0; i < 2; i++) begin
            e.angle[i] = m_enc(m_cur[i]);
            e.busy[i]  = (m_cur[i] != m_tgt[i]);
         end
         e.ready = m_pend ? 2'b00 : 2'b11;
         e.tick  = ((m_k % FC) == FC - 1) ? 2'b11 : 2'b00;
         q.push_back(e);
      end
   end

   // Monitor: compares DUT outputs against the oldest prediction.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset && q.size() > 0) begin
         e = q.pop_front();
         for (int i = 0; i < 2; i++) begin
            check($sformatf("angle%0d", i), angle[i], e.angle[i]);
            check($sformatf("busy%0d", i), 16'(busy[i]), 16'(e.busy[i]));
            check($sformatf("cmd_err%0d", i), 16'(cmd_err[i]), 16'(e.err[i]));
            check($sformatf("cmd_ready%0d", i), 16'(cmd_ready[i]), 16'(e.ready[i]));
            check($sformatf("frame_tick%0d", i), 16'(frame_tick[i]), 16'(e.tick[i]));
         end
      end
   end

   task automatic send(input logic [15:0] w);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_angle = w;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_angle%0d", tag, i), angle[i], 16'h55A0);
         check($sformatf("%s_busy%0d", tag, i), 16'(busy[i]), 16'h0);
         check($sformatf("%s_ready%0d", tag, i), 16'(cmd_ready[i]), 16'h1);
         check($sformatf("%s_err%0d", tag, i), 16'(cmd_err[i]), 16'h0);
         check($sformatf("%s_tick%0d", tag, i), 16'(frame_tick[i]), 16'h0);
      end
   endtask

   initial begin
      logic [15:0] corn [8];
      logic [15:0] w;
      corn = '{16'h597C, 16'h5A00, 16'hC500, 16'h3C00, 16'h7C00, 16'h7E00, 16'h0001, 16'h5B40};

      wait_cyc(3);
      #1 check_reset_state("rst");
      #1 reset = 1'b1;

      send(16'h5060); wait_cyc(57 * FC);
      send(16'h59A0); wait_cyc(147 * FC);
      send(16'h597C); wait_cyc(10 * FC);
      send(16'h5A00); wait_cyc(10 * FC);
      send(16'hC500); wait_cyc(182 * FC);
      send(16'h3C00); wait_cyc(3 * FC);
      send(16'h7C00); wait_cyc(3 * FC);
      send(16'h59A0); wait_cyc(5 * FC);
      send(16'h5060); wait_cyc(4 * FC);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       w = m_enc(int'($urandom_range(0, 180)));
            1:       w = 16'($urandom);
            default: w = corn[$urandom_range(0, 7)];
         endcase
         send(w);
         wait_cyc(int'($urandom_range(0, 400)));
      end

      // Async reset in the middle of a slew.
      send(16'h0000); wait_cyc(182 * FC);
      send(16'h59A0); wait_cyc(100);
      @(posedge clk);
      #3 reset = 1'b0;
      #1 check_reset_state("midrst");
      @(negedge clk);
      #2 reset = 1'b1;
      wait_cyc(3 * FC);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
